// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  localparam int unsigned ARB_N_DEF        = 4;
  localparam int unsigned ARB_MAX_HOLD_DEF = 16;
  localparam int unsigned ARB_N_MAX        = 16;
  localparam int unsigned ARB_IDW_MAX      = 4;

  // Binary index of a one-hot vector (zero for an all-zero vector).
  function automatic logic [ARB_IDW_MAX-1:0] onehot2idx(input logic [ARB_N_MAX-1:0] oh);
    logic [ARB_IDW_MAX-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(ARB_N_MAX); i++) begin
      if (oh[i]) idx = idx | ARB_IDW_MAX'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/masked_prio_enc.sv
// Rotating-priority encoder: lowest set request at or above ptr, else wrap
// to the lowest set request below ptr.
module masked_prio_enc
  import arb_pkg::*;
#(
  parameter int unsigned N   = ARB_N_DEF,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   win,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
    // Nothing at or above ptr: the first hit now is necessarily below ptr.
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign any = |req;
  assign idx = IDW'(onehot2idx(ARB_N_MAX'(win)));

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with hold-until-release grants.
// Optional tenure limit enabled by defining ARB_HOLD_LIMIT_EN.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = ARB_N_DEF,
  parameter int unsigned IDW      = $clog2(N),
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           expired
);

  if (N < 2 || N > ARB_N_MAX || MAX_HOLD < 2) begin : g_bad_cfg
    $error("rr_arbiter: unsupported N or MAX_HOLD");
  end

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   gnt_d;
  logic [IDW-1:0] gnt_id_d;
  logic           busy, rel, revoke, new_grant;
  logic [IDW-1:0] nxt_ptr;
  logic [N-1:0]   enc_req;
  logic [IDW-1:0] enc_ptr;
  logic [N-1:0]   enc_win;
  logic [IDW-1:0] enc_idx;
  logic           enc_any;

  assign busy    = (state_q == ARB_BUSY);
  assign rel     = busy && !req[gnt_id];
  assign nxt_ptr = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);

  // In BUSY the encoder only matters for a handoff, which excludes the owner.
  assign enc_req = busy ? (req & ~gnt) : req;
  assign enc_ptr = busy ? nxt_ptr : ptr_q;

  masked_prio_enc #(.N(N), .IDW(IDW)) u_enc (
    .req (enc_req),
    .ptr (enc_ptr),
    .win (enc_win),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt       <= gnt_d;
      gnt_id    <= gnt_id_d;
      gnt_valid <= |gnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt;
    gnt_id_d  = gnt_id;
    new_grant = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (enc_any) begin
          gnt_d     = enc_win;
          gnt_id_d  = enc_idx;
          state_d   = ARB_BUSY;
          new_grant = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (rel || revoke) begin
          ptr_d = nxt_ptr;
          if (enc_any) begin
            gnt_d     = enc_win;
            gnt_id_d  = enc_idx;
            new_grant = 1'b1;
          end else begin
            gnt_d    = '0;
            gnt_id_d = '0;
            state_d  = ARB_IDLE;
          end
        end
      end
      default: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        state_d  = ARB_IDLE;
      end
    endcase
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD);

  logic [CW-1:0] hold_cnt;

  // A genuine release on the last counted cycle wins over revocation.
  assign revoke = busy && req[gnt_id] && (hold_cnt == CW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      expired  <= 1'b0;
    end else begin
      expired <= revoke;
      if (new_grant)   hold_cnt <= '0;
      else if (busy)   hold_cnt <= hold_cnt + CW'(1);
    end
  end
`else
  assign revoke  = 1'b0;
  assign expired = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a behavioural model predicts each cycle.
module tb_rr_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned IDW      = 2;
  localparam int unsigned MAX_HOLD = 4;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           expired;

  always #5 clk = ~clk;

  rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .expired   (expired)
  );

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    logic           valid;
    logic           exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bit m_busy;
  int m_owner, m_ptr, m_cnt;

  always @(negedge clk) begin
    if (reset_n) assert ($onehot0(gnt)) else $error("onehot violated: gnt=%b", gnt);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < int'(N); k++) begin
      if (r[(p + k) % int'(N)]) return (p + k) % int'(N);
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // Drive one cycle of req, predict the result, then compare after the edge.
  task automatic step(input logic [N-1:0] r);
    exp_t e, got;
    bit rel, rev;
    logic [N-1:0] rr;
    @(negedge clk);
    req = r;
    e.exp = 1'b0;
    if (!m_busy) begin
      if (r != '0) begin
        m_owner = pick(r, m_ptr); m_busy = 1'b1; m_cnt = 0;
      end
    end else begin
      rel = !r[m_owner];
      rev = HOLD_EN && !rel && (m_cnt == int'(MAX_HOLD) - 1);
      if (rel || rev) begin
        m_ptr = (m_owner + 1) % int'(N);
        rr = r & ~(N'(1) << m_owner);
        if (rr != '0) begin
          m_owner = pick(rr, m_ptr); m_cnt = 0;
        end else begin
          m_busy = 1'b0;
        end
        e.exp = rev;
      end else begin
        m_cnt++;
      end
    end
    e.gnt   = m_busy ? (N'(1) << m_owner) : '0;
    e.id    = m_busy ? IDW'(m_owner) : '0;
    e.valid = m_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("gnt",       32'(gnt),       32'(got.gnt));
      check("gnt_id",    32'(gnt_id),    32'(got.id));
      check("gnt_valid", 32'(gnt_valid), 32'(got.valid));
      check("expired",   32'(expired),   32'(got.exp));
    end
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset_n = 1'b0;
    req     = 4'b1111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",       32'(gnt),       32'd0);
    check("rst_gnt_id",    32'(gnt_id),    32'd0);
    check("rst_gnt_valid", 32'(gnt_valid), 32'd0);
    check("rst_expired",   32'(expired),   32'd0);
    reset_n = 1'b1;

    // First grant after reset, then rotation with 3-cycle tenures.
    step(4'b1111);
    check("first_gnt", 32'(gnt), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      check("rot_order", 32'(gnt_id), 32'(order[k]));
      if (k < 4) begin
        step(4'b1111);
        step(4'b1111);
        step(~(4'(1) << m_owner));
      end
    end

    // Reset while a grant is held drops gnt without waiting for an edge.
    @(negedge clk);
    #2 reset_n = 1'b0;
    req = '0;
    #1;
    check("midrst_gnt",   32'(gnt),       32'd0);
    check("midrst_valid", 32'(gnt_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Pointer wrap: owner 3 releases with 0101 pending.
    step(4'b1000);
    step(4'b1000);
    step(4'b0101);
    check("wrap_gnt", 32'(gnt), 32'b0001);
    step(4'b0000);

    // Single requester in and out.
    step(4'b0100);
    check("single_gnt", 32'(gnt), 32'b0100);
    step(4'b0100);
    step(4'b0000);
    check("single_idle", 32'(gnt), 32'd0);

    // Release and a new request in the same cycle.
    step(4'b0010);
    step(4'b0010);
    step(4'b0100);
    check("same_cycle_gnt", 32'(gnt), 32'b0100);
    step(4'b0000);

    // Long tenure: bounded only when the hold limit is built in.
    step(4'b0011);
    for (int k = 0; k < 4; k++) step(4'b0011);
    check("hold_gnt", 32'(gnt), HOLD_EN ? 32'b0010 : 32'b0001);
    check("hold_exp", 32'(expired), HOLD_EN ? 32'd1 : 32'd0);
    for (int k = 0; k < 6; k++) step(4'b0011);
    step(4'b0000);
    for (int k = 0; k < 8; k++) step(4'b0001);
    step(4'b0000);

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) step(4'($urandom_range(0, 15)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one downstream resource, such as an encoder datapath or a bus port, among N requesters. It accepts one `req` line per requester, grants exactly one requester at a time, and holds that grant until the owner releases it. Fairness comes from a rotating priority pointer fed into a masked priority encoder. It sits between the requesting agents and the shared resource and drives that resource's select/enable.

## Interface
- `N`, 4: number of requesters; range 2..16.
- `IDW`, `$clog2(N)`: width of the grant index.
- `MAX_HOLD`, 16: maximum tenure in cycles; used only when `ARB_HOLD_LIMIT_EN` is defined; must be ≥ 2.

Ports:
- `clk` · input · 1 · single clock; all state changes on the rising edge.
- `reset_n` · input · 1 · asynchronous, active-low reset.
- `req` · input · N · request per requester; level-sensitive; held high for the whole transaction.
- `gnt` · output · N · one-hot grant, or all zeros; registered.
- `gnt_id` · output · IDW · binary index of the current owner; 0 when idle.
- `gnt_valid` · output · 1 · OR of `gnt`; high in BUSY.
- `expired` · output · 1 · one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- **Reset values:** state=IDLE, `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `expired`=0, pointer `ptr`=0, hold counter=0.
- **Arbitration function `pick(r, ptr)`:**
  - Search for the lowest set index ≥ `ptr`.
  - If there is none, wrap to the lowest set index < `ptr`.
  - The result is undefined when `r`=0 and is never used in that case.
- **IDLE:**
  - `req`=0: stay in IDLE.
  - Otherwise: grant `pick(req, ptr)` and go to BUSY.
- **BUSY, owner `o` keeps `req[o]`=1:** hold the grant; `ptr` is unchanged.
- **BUSY, owner drops `req[o]`=0:** this is a release.
  - Set `ptr` to `(o+1) mod N`.
  - If `req & ~(1<<o)` ≠ 0, hand off directly to `pick(req & ~(1<<o), (o+1) mod N)` and stay in BUSY. There is no idle gap.
  - Otherwise go to IDLE.
- **Invariants:**
  - `gnt` is always one-hot or zero; two bits are never high.
  - `gnt_id` matches `gnt` every cycle.
- **Non-owner requests:** these may rise or fall at any time. They are only sampled at arbitration points.
- **Simultaneous events:**
  - If release and new requests arrive in the same cycle, the new requests are eligible for that handoff.
  - A request that rises and falls while another requester owns the grant is never granted.
- **Reset mid-transaction:** `gnt` drops immediately (asynchronously). After reset deassertion, arbitration restarts from `ptr`=0.

## Timing
- **Request-to-grant latency:** 1 cycle. A `req` seen at edge k in IDLE gives `gnt` high after edge k.
- **Release-to-next-grant latency:** 1 cycle. `req[o]` low at edge k produces the new `gnt` after edge k.
- **Owner obligations:** the owner may use the resource in every cycle in which its `gnt` bit is high. The release takes effect the cycle after `req[o]` falls.
- **Reset:** asserted asynchronously; deassertion is expected to be synchronized externally to `clk`.

## Configuration
- **Macro:** `ARB_HOLD_LIMIT_EN`.
- **Defined:**
  - An IDW-independent counter of width `$clog2(MAX_HOLD)` clears on every new grant and increments each BUSY cycle.
  - When the counter reaches `MAX_HOLD-1` while `req[o]`=1, the grant is revoked on the next edge.
  - After revocation, `ptr` becomes `(o+1) mod N`.
  - The handoff then follows the release rule, with `o` excluded.
  - If no other requester is pending, the arbiter goes to IDLE for at least one cycle. The revoked owner re-arbitrates from IDLE.
  - `expired`=1 for exactly the cycle in which the new `gnt` (or zero) is first visible.
  - A genuine release on the final counted cycle takes precedence: `expired` stays 0.
- **Undefined:**
  - No counter is built.
  - Tenure is unlimited.
  - `expired` is tied to 0.

## Structure
- **Package `arb_pkg`:**
  - State enum `{ARB_IDLE, ARB_BUSY}`.
  - Default constants for `N` and `MAX_HOLD`.
  - A helper function that converts a one-hot vector to its binary index.
- **Sub-module `masked_prio_enc`:**
  - Purely combinational; parameterized by N.
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner, binary index, and `any`.
  - Implements `pick`; it is the only place that contains a priority `casez`/loop.
- **`rr_arbiter` top:** holds the FSM, `ptr`, the output registers and the optional hold counter.

## Test plan
1. **Reset behaviour:** reset with `req`=4'b1111, then release reset → `gnt`=0001 one cycle after the first edge. Asserting `reset_n`=0 mid-grant → `gnt`=0000 immediately.
2. **Rotation:** `req`=1111 held; each owner drops its `req` for one cycle after 3 cycles of tenure → grant order 0,1,2,3,0. Direct handoff each time, so `gnt_valid` has no gap.
3. **Pointer wrap:** owner 3 releases while `req`=0101 → the next grant is 0 (`ptr` wraps to 0), not 2.
4. **Single requester:** `req`=0100 only → `gnt`=0100 after 1 cycle. Drop `req` → `gnt`=0 next cycle and state returns to IDLE.
5. **Hold limit (`ARB_HOLD_LIMIT_EN`, `MAX_HOLD`=4):** `req`=0011 held → `gnt`=0001 for 4 cycles, then `gnt`=0010 with `expired`=1 for one cycle. With `req`=0001 only → `gnt` goes to 0 for 1 cycle, then back to 0001.
6. **Same cycle:** release and new request arrive together: owner 1 drops while `req[2]` rises in that same cycle → `gnt`=0100 on the next edge, one-hot is never violated (assertion active throughout).
